syrup_mem_traffic_gen: RTL and testbench
========================================

// Module: syrup_mem_traffic_gen
// PURPOSE
//  Parametrised traffic generator/checker for one SyrupMemory1P port. Strided write sweep,
//  read sweep, or write-then-read-verify over NUM_WORDS words. Counts read mismatches.
//  Drives status and heartbeat LEDs. Sits in userlogic between the memory and the io LEDs.
// PARAMETERS
//  ADDR_WIDTH    24  memory address width (bytes)
//  DATA_WIDTH    32  memory data width
//  BASE_ADDR     0   first address of every sweep
//  STRIDE        4   address increment per word
//  NUM_WORDS     256 words per sweep (>=1)
//  MODE          2   0=read sweep only, 1=write sweep only, 2=write then read-verify
//  READ_LATENCY  1   cycles from RE sample to valid Q (>=1)
//  SEED          0   pattern seed, DATA_WIDTH bits
//  LED_WIDTH     8   LED width (>=4)
// PORTS
//  CLK       in   1            clock
//  RST       in   1            synchronous, active-high reset
//  START     in   1            one-cycle start pulse
//  BUSY      out  1            sweep in progress
//  DONE      out  1            sweep finished; held until next START or RST
//  ERROR     out  1            sticky: at least one mismatch this run
//  ERR_COUNT out  16           mismatch count, saturates at 16'hFFFF
//  ERR_ADDR  out  ADDR_WIDTH   address of first mismatch this run
//  ADDR      out  ADDR_WIDTH   memory address
//  D         out  DATA_WIDTH   memory write data
//  WE        out  1            memory write enable
//  RE        out  1            memory read enable
//  BE        out  DATA_WIDTH/8 byte enables, all ones
//  Q         in   DATA_WIDTH   memory read data
//  LED       out  LED_WIDTH    {ERROR, DONE, BUSY, heartbeat[LED_WIDTH-4:0]}
// BEHAVIOUR
//  - Reset: all outputs 0 except BE (all ones). State IDLE; check pipeline and heartbeat cleared.
//  - FSM: IDLE -> (START) WRITE or READ per MODE. WRITE -> after NUM_WORDS: READ if MODE=2,
//    else FIN. READ -> DRAIN -> FIN after READ_LATENCY cycles. FIN -> (START) new run.
//  - START while BUSY is ignored. START in IDLE or FIN clears DONE, ERROR, ERR_COUNT and
//    ERR_ADDR, and sets BUSY on the next edge.
//  - Each WRITE/READ cycle issues exactly one access (WE or RE = 1) with index i = 0..NUM_WORDS-1.
//  - ADDR = BASE_ADDR + i*STRIDE mod 2^ADDR_WIDTH; wraps silently.
//  - Pattern P(i) = ADDR XOR SEED, where ADDR is zero-extended or truncated to DATA_WIDTH.
//    In WRITE, D = P(i). In READ, D = 0.
//  - Check pipe: depth-READ_LATENCY shift register of {valid, P(i), ADDR}. Compare Q with the
//    expected value when the entry exits.
//  - On mismatch: ERR_COUNT += 1 (saturating) and ERROR = 1. ERR_ADDR is captured only on the
//    first mismatch.
//  - MODE=0 checks against P(i), so contents must be preloaded.
//  - WE and RE are never both 1. Both are 0 in IDLE, DRAIN and FIN.
//  - BUSY = 1 in WRITE/READ/DRAIN. DONE is set on entry to FIN; BUSY and DONE are never both 1.
//  - Total run length = NUM_WORDS (+NUM_WORDS if MODE=2) + READ_LATENCY (reads only) + 1 cycles.
//  - Heartbeat: free-running 24-bit counter; LED low bits = counter[23 -: LED_WIDTH-3].
//  - RST mid-run: WE/RE drop at that edge; pending checks are discarded; no counts update.
// CONFIGURATION
//  SYRUP_TGEN_LFSR_EN defined: P(i) comes from a Galois LFSR instead of ADDR XOR SEED.
//    - Width max(DATA_WIDTH,32); taps 32,22,2,1; output is the low DATA_WIDTH bits.
//    - Loaded with SEED|1 at the start of each WRITE and each READ phase.
//    - Advances once per issued access, so write and read sequences match.
//  Undefined: ADDR XOR SEED pattern; no LFSR logic is instantiated.
// TESTING
//  T1 MODE=2, NUM_WORDS=4, READ_LATENCY=1, ideal memory model:
//     WE at 0,4,8,12 with D = 0,4,8,12; then RE at 0,4,8,12.
//     Expect DONE=1, ERROR=0, ERR_COUNT=0.
//  T2 As T1; model flips Q[0] on reads of addr 8 -> ERR_COUNT=1, ERR_ADDR=8, ERROR=1, LED[7]=1.
//  T3 ADDR_WIDTH=4, BASE_ADDR=12, STRIDE=4, NUM_WORDS=3 -> ADDR sequence 12, 0, 4 in each phase.
//  T4 READ_LATENCY=3, fault at the last word -> mismatch still counted during DRAIN.
//     DONE rises exactly 3 cycles after the last RE.
//  T5 START pulsed again mid-WRITE -> ignored, sequence unchanged.
//     RST at word 2 -> WE=0 next cycle, all outputs 0, state IDLE.
//  T6 SYRUP_TGEN_LFSR_EN, SEED=0 -> first D = 32'h00000001.
//     Read-verify passes; a second START rerun also passes with ERR_COUNT=0.

Source files
------------

// File: rtl/syrup_mem_traffic_gen.sv
// syrup_mem_traffic_gen
// Traffic generator/checker for one single-port memory. Runs a strided write
// sweep, a read sweep, or a write sweep followed by a read-verify sweep over
// NUM_WORDS words, and counts read mismatches.
// Build option: define SYRUP_TGEN_LFSR_EN to generate the data pattern from a
// Galois LFSR instead of ADDR XOR SEED.
//
// Memory handshake: one access per WRITE/READ cycle, signalled by WE or RE
// held for exactly that cycle. There is no back-pressure. Read data on Q is
// valid READ_LATENCY cycles after the cycle in which RE was high, and is
// sampled by the checker at the end of that cycle.
module syrup_mem_traffic_gen #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned STRIDE       = 4,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned MODE         = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] SEED = '0,
  parameter int unsigned LED_WIDTH    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERROR,
  output logic [15:0]               ERR_COUNT,
  output logic [ADDR_WIDTH-1:0]     ERR_ADDR,
  output logic [ADDR_WIDTH-1:0]     ADDR,
  output logic [DATA_WIDTH-1:0]     D,
  output logic                      WE,
  output logic                      RE,
  output logic [DATA_WIDTH/8-1:0]   BE,
  input  logic [DATA_WIDTH-1:0]     Q,
  output logic [LED_WIDTH-1:0]      LED,
  output logic [2:0]                DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int unsigned LAST_IDX  = NUM_WORDS - 1;
  localparam int unsigned LAST_DRN  = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);

  state_t                  state_q;
  logic [31:0]             idx_q;
  logic [31:0]             drain_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic                    we_q;
  logic                    re_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [15:0]             err_count_q;
  logic [ADDR_WIDTH-1:0]   err_addr_q;
  logic [23:0]             hb_q;

  // Check pipe: one entry per cycle, valid only for cycles that issued a read.
  logic                    pipe_v_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_e_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_a_q [READ_LATENCY];

  logic                    start_ok;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   pat_first;  // pattern of index 0 of a phase
  logic [DATA_WIDTH-1:0]   pat_adv;    // pattern of the next index in a phase
  logic [DATA_WIDTH-1:0]   exp_cur;    // pattern of the access being issued now

  assign start_ok  = START && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign last_word = (idx_q == LAST_IDX);
  assign addr_next = addr_q + STEP;

`ifdef SYRUP_TGEN_LFSR_EN
  localparam int unsigned LW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam logic [LW-1:0] TAPS = LW'(32'h8020_0003);  // taps 32,22,2,1
  localparam logic [LW-1:0] SEED_INIT = LW'(SEED) | LW'(1);

  logic [LW-1:0] lfsr_q;
  logic [LW-1:0] lfsr_nx;
  logic          phase_load;
  logic          phase_adv;

  assign lfsr_nx    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  // Reload at the start of every WRITE and every READ phase so both phases
  // see the same sequence; advance once per issued access.
  assign phase_load = start_ok || ((state_q == S_WRITE) && last_word && (MODE == 2));
  assign phase_adv  = ((state_q == S_WRITE) || (state_q == S_READ)) && !last_word;
  assign pat_first  = SEED_INIT[DATA_WIDTH-1:0];
  assign pat_adv    = lfsr_nx[DATA_WIDTH-1:0];
  assign exp_cur    = lfsr_q[DATA_WIDTH-1:0];

  // LFSR state always holds the pattern of the access currently on the bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= '0;
    end else if (phase_load) begin
      lfsr_q <= SEED_INIT;
    end else if (phase_adv) begin
      lfsr_q <= lfsr_nx;
    end
  end
`else
  function automatic logic [DATA_WIDTH-1:0] pat_of(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ SEED;
  endfunction

  assign pat_first = pat_of(BASE);
  assign pat_adv   = pat_of(addr_next);
  assign exp_cur   = pat_of(addr_q);
`endif

  // Sweep FSM with registered memory-side and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (START) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
            idx_q  <= '0;
            addr_q <= BASE;
            if (MODE == 0) begin
              state_q <= S_READ;
              re_q    <= 1'b1;
              d_q     <= '0;
            end else begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              d_q     <= pat_first;
            end
          end
        end
        S_WRITE: begin
          if (!last_word) begin
            idx_q  <= idx_q + 32'd1;
            addr_q <= addr_next;
            d_q    <= pat_adv;
          end else if (MODE == 2) begin
            state_q <= S_READ;
            we_q    <= 1'b0;
            re_q    <= 1'b1;
            idx_q   <= '0;
            addr_q  <= BASE;
            d_q     <= '0;
          end else begin
            state_q <= S_FIN;
            we_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_READ: begin
          if (!last_word) begin
            idx_q  <= idx_q + 32'd1;
            addr_q <= addr_next;
          end else begin
            state_q <= S_DRAIN;
            re_q    <= 1'b0;
            drain_q <= '0;
          end
        end
        S_DRAIN: begin
          // Wait for the last read's data to leave the check pipe.
          if (drain_q == LAST_DRN) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Check pipe and mismatch bookkeeping; a new run clears the run's results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < int'(READ_LATENCY); s++) begin
        pipe_v_q[s] <= 1'b0;
        pipe_e_q[s] <= '0;
        pipe_a_q[s] <= '0;
      end
      error_q     <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      pipe_v_q[0] <= re_q;
      pipe_e_q[0] <= exp_cur;
      pipe_a_q[0] <= addr_q;
      for (int s = 1; s < int'(READ_LATENCY); s++) begin
        pipe_v_q[s] <= pipe_v_q[s-1];
        pipe_e_q[s] <= pipe_e_q[s-1];
        pipe_a_q[s] <= pipe_a_q[s-1];
      end
      if (start_ok) begin
        error_q     <= 1'b0;
        err_count_q <= '0;
        err_addr_q  <= '0;
      end else if (pipe_v_q[READ_LATENCY-1] && (Q != pipe_e_q[READ_LATENCY-1])) begin
        if (err_count_q != 16'hFFFF) begin
          err_count_q <= err_count_q + 16'd1;
        end
        if (!error_q) begin
          err_addr_q <= pipe_a_q[READ_LATENCY-1];
        end
        error_q <= 1'b1;
      end
    end
  end

  // Free-running heartbeat counter for the LED bar.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_q + 24'd1;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;
  assign ERR_COUNT = err_count_q;
  assign ERR_ADDR  = err_addr_q;
  assign ADDR      = addr_q;
  assign D         = d_q;
  assign WE        = we_q;
  assign RE        = re_q;
  assign BE        = '1;
  assign LED       = {error_q, done_q, busy_q, hb_q[23 -: (LED_WIDTH-3)]};
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_syrup_mem_traffic_gen.sv
// Bench for syrup_mem_traffic_gen: four instances with different geometries
// share one clock and reset, each behind its own ideal memory with an
// optional single-bit read fault. Expected per-cycle bus activity and
// end-of-run results come from a sweep model built from address arithmetic.
module tb_syrup_mem_traffic_gen;

  localparam int NDUT = 4;
  localparam int unsigned CFG_AW     [NDUT] = '{24, 4, 24, 24};
  localparam int unsigned CFG_BASE   [NDUT] = '{0, 12, 32'hFFFFF0, 40};
  localparam int unsigned CFG_STRIDE [NDUT] = '{4, 4, 12, 8};
  localparam int unsigned CFG_N      [NDUT] = '{4, 3, 5, 5};
  localparam int unsigned CFG_MODE   [NDUT] = '{2, 2, 0, 1};
  localparam int unsigned CFG_LAT    [NDUT] = '{1, 3, 2, 2};
  localparam int unsigned CFG_LEDW   [NDUT] = '{8, 8, 8, 27};
  localparam logic [31:0] CFG_SEED   [NDUT] = '{32'h0, 32'h5A5A_00F0, 32'hC0DE_0001, 32'hFFFF_FFFF};

  localparam logic [63:0] MSK_ALL   = 64'h0FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSK_FLAGS = 64'h0F00_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] start_r;
  wire  [NDUT-1:0] busy_w, done_w, error_w, we_w, re_w;
  wire  [15:0]     errc_w  [NDUT];
  wire  [23:0]     eaddr_w [NDUT];
  wire  [23:0]     addr_w  [NDUT];
  wire  [31:0]     d_w     [NDUT];
  wire  [3:0]      be_w    [NDUT];
  wire  [31:0]     q_w     [NDUT];
  wire  [26:0]     led_w   [NDUT];
  wire  [2:0]      dbg_w   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned AWG = CFG_AW[g];
    localparam int unsigned LWG = CFG_LEDW[g];
    wire [AWG-1:0] addr_n;
    wire [AWG-1:0] eaddr_n;
    wire [LWG-1:0] led_n;

    syrup_mem_traffic_gen #(
      .ADDR_WIDTH  (AWG),
      .DATA_WIDTH  (32),
      .BASE_ADDR   (CFG_BASE[g]),
      .STRIDE      (CFG_STRIDE[g]),
      .NUM_WORDS   (CFG_N[g]),
      .MODE        (CFG_MODE[g]),
      .READ_LATENCY(CFG_LAT[g]),
      .SEED        (CFG_SEED[g]),
      .LED_WIDTH   (LWG)
    ) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .START    (start_r[g]),
      .BUSY     (busy_w[g]),
      .DONE     (done_w[g]),
      .ERROR    (error_w[g]),
      .ERR_COUNT(errc_w[g]),
      .ERR_ADDR (eaddr_n),
      .ADDR     (addr_n),
      .D        (d_w[g]),
      .WE       (we_w[g]),
      .RE       (re_w[g]),
      .BE       (be_w[g]),
      .Q        (q_w[g]),
      .LED      (led_n),
      .DBG_STATE(dbg_w[g])
    );

    assign addr_w[g]  = 24'(addr_n);
    assign eaddr_w[g] = 24'(eaddr_n);
    assign led_w[g]   = 27'(led_n);
  end

  // ---------------- ideal memories with optional read fault ----------------
  logic [31:0] mem [int];
  logic [31:0] qpipe [NDUT][3];
  logic [NDUT-1:0] flt_en;
  logic [23:0] flt_addr [NDUT];
  logic [31:0] rd_v;

  function automatic int m_key(input int k, input logic [23:0] a);
    return k * 32'h0100_0000 + int'({8'd0, a});
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (we_w[k] === 1'b1) mem[m_key(k, addr_w[k])] = d_w[k];
      rd_v = 32'hDEAD_BEEF;
      if (re_w[k] === 1'b1) begin
        rd_v = mem.exists(m_key(k, addr_w[k])) ? mem[m_key(k, addr_w[k])] : 32'd0;
        if (flt_en[k] && (addr_w[k] == flt_addr[k])) rd_v[0] = ~rd_v[0];
      end
      qpipe[k][0] <= rd_v;
      for (int j = 1; j < 3; j++) qpipe[k][j] <= qpipe[k][j-1];
    end
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_q
    assign q_w[g] = qpipe[g][CFG_LAT[g]-1];
  end

  // Heartbeat reference: cycles since reset release, modulo 2^24.
  logic [23:0] hb_m;
  always @(posedge clk) hb_m = rst ? 24'd0 : hb_m + 24'd1;

  // ---------------- sweep model ----------------
  function automatic logic [23:0] m_addr(input int k, input int i);
    longint a;
    a = longint'(CFG_BASE[k]) + longint'(i) * longint'(CFG_STRIDE[k]);
    return 24'(a & ((longint'(1) << CFG_AW[k]) - 1));
  endfunction

  function automatic logic [31:0] m_pat(input int k, input int i);
`ifdef SYRUP_TGEN_LFSR_EN
    logic [31:0] s;
    s = CFG_SEED[k] | 32'd1;
    for (int n = 0; n < i; n++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    return s;
`else
    return 32'(m_addr(k, i)) ^ CFG_SEED[k];
`endif
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic dn, input logic w,
                                       input logic r, input logic [23:0] a, input logic [31:0] dd);
    return {4'd0, b, dn, w, r, a, dd};
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input int k, input string tag);
    check({tag, ".flags"}, 64'({busy_w[k], done_w[k], error_w[k], we_w[k], re_w[k], dbg_w[k], errc_w[k]}), 64'd0);
    check({tag, ".addrs"}, 64'({eaddr_w[k], addr_w[k]}), 64'd0);
    check({tag, ".d_led"}, 64'({d_w[k], led_w[k]}), 64'd0);
    check({tag, ".be"}, 64'(be_w[k]), 64'hF);
  endtask

  // ---------------- driver: one run with cycle-exact checking ----------------
  // mid_start: cycle to re-pulse START (-1 none, -2 random busy cycle)
  // rst_at:    cycle after which RST is asserted (-1 none)
  task automatic run_check(input int k, input int mid_start, input int rst_at, input string tag);
    logic [63:0] exp_q[$];
    logic [63:0] msk_q[$];
    logic [63:0] got;
    logic [23:0] a, first_ea;
    logic [31:0] stored, seen;
    logic [26:0] el;
    int mode, nw, nr, lat, busy_cyc, n_err_m, mid, lw;

    mode = int'(CFG_MODE[k]);
    nw   = (mode != 0) ? int'(CFG_N[k]) : 0;
    nr   = (mode != 1) ? int'(CFG_N[k]) : 0;
    lat  = int'(CFG_LAT[k]);
    n_err_m  = 0;
    first_ea = '0;

    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 1'b0, m_addr(k, i), m_pat(k, i)));
      msk_q.push_back(MSK_ALL);
    end
    for (int i = 0; i < nr; i++) begin
      a = m_addr(k, i);
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b1, a, 32'd0));
      msk_q.push_back(MSK_ALL);
      stored = (mode == 2) ? m_pat(k, i) : mem[m_key(k, a)];
      seen   = stored ^ ((flt_en[k] && (a == flt_addr[k])) ? 32'd1 : 32'd0);
      if (seen != m_pat(k, i)) begin
        if (n_err_m == 0) first_ea = a;
        n_err_m++;
      end
    end
    if (nr > 0) begin
      for (int i = 0; i < lat; i++) begin
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 32'd0));
        msk_q.push_back(MSK_FLAGS);
      end
    end
    busy_cyc = exp_q.size();
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 32'd0));
    msk_q.push_back(MSK_FLAGS);

    mid = mid_start;
    if (mid_start == -2) mid = int'($urandom_range(1, busy_cyc - 1));

    @(negedge clk); start_r[k] = 1'b1;
    @(negedge clk); start_r[k] = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j > 0) @(negedge clk);
      start_r[k] = (j == mid);
      got = pack(busy_w[k], done_w[k], we_w[k], re_w[k], addr_w[k], d_w[k]);
      check($sformatf("%s.cyc%0d", tag, j), got & msk_q[j], exp_q[j] & msk_q[j]);
      if (j == rst_at) begin
        start_r[k] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero(k, {tag, ".after_rst"});
        rst = 1'b0;
        repeat (lat + 2) @(negedge clk);
        check({tag, ".no_late_err"}, 64'({error_w[k], errc_w[k]}), 64'd0);
        return;
      end
    end

    check({tag, ".err_count"}, 64'(errc_w[k]), 64'(n_err_m));
    check({tag, ".error"}, 64'(error_w[k]), 64'(n_err_m != 0));
    if (n_err_m != 0) check({tag, ".err_addr"}, 64'(eaddr_w[k]), 64'(first_ea));
    lw = int'(CFG_LEDW[k]);
    el = 27'(hb_m >> (27 - lw));
    el[lw-2] = 1'b1;
    el[lw-1] = (n_err_m != 0);
    check({tag, ".led"}, 64'(led_w[k]), 64'(el));
    @(negedge clk);
    check({tag, ".done_held"}, 64'({busy_w[k], done_w[k], we_w[k], re_w[k]}), 64'b0100);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    int bad, k;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start_r = '0;
    flt_en = '0;
    for (int i = 0; i < NDUT; i++) flt_addr[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_idle_zero(i, $sformatf("reset_k%0d", i));
    rst = 1'b0;

    // Preload the read-only instance; at least one word is corrupted.
    bad = int'($urandom_range(0, CFG_N[2] - 1));
    for (int i = 0; i < int'(CFG_N[2]); i++) begin
      v = m_pat(2, i);
      if ((i == bad) || ($urandom_range(0, 3) == 0)) v = v ^ (32'd1 << $urandom_range(0, 31));
      mem[m_key(2, m_addr(2, i))] = v;
    end

    run_check(0, -1, -1, "t1_clean");
    flt_addr[0] = 24'd8;
    flt_en[0] = 1'b1;
    run_check(0, -1, -1, "t2_fault8");
    flt_en[0] = 1'b0;
    run_check(0, -2, -1, "t5_restart_ignored");
    run_check(0, -1, 2, "t5_rst_write");
    run_check(0, -1, -1, "rerun_clean");

    flt_addr[1] = m_addr(1, int'(CFG_N[1]) - 1);
    flt_en[1] = 1'b1;
    run_check(1, -1, -1, "t4_fault_last");
    flt_addr[1] = m_addr(1, 0);
    run_check(1, -1, int'(CFG_N[1]) + 1, "rst_pending");
    flt_en[1] = 1'b0;
    run_check(1, -2, -1, "t3_wrap_clean");

    run_check(2, -2, -1, "mode0_preload");
    run_check(3, -2, -1, "mode1_write");

    for (int r = 0; r < 8; r++) begin
      k = int'($urandom_range(0, NDUT - 1));
      flt_en[k] = 1'($urandom_range(0, 1));
      flt_addr[k] = m_addr(k, int'($urandom_range(0, CFG_N[k] - 1)));
      run_check(k, -2, -1, $sformatf("rand%0d_k%0d", r, k));
      flt_en[k] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
